// File: rtl/mdio_ctrl.sv
// MDIO management sequencer: MDC divider, host-command / status-poll arbitration
// and the start/done handshake with the downstream MDIO frame engine.
module mdio_ctrl #(
  parameter int         MDC_DIV     = 25,
  parameter int         POLL_PERIOD = 50000,
  parameter logic [4:0] POLL_REG    = 5'd1,
  parameter int         LINK_BIT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mdc,
  input  logic        cmd_req,
  input  logic        cmd_rw,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        cmd_ack,
  output logic [15:0] cmd_rdata,
  output logic        busy,
  input  logic        poll_en,
  output logic        link_up,
  output logic        poll_valid,
  output logic        m_start,
  output logic        m_rw,
  output logic [4:0]  m_phy,
  output logic [4:0]  m_reg,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_done
);
  localparam int DW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(MDC_DIV - 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          mdc_q, mdc_d;
  logic          owner_q, owner_d;   // 1 = poll frame, 0 = host frame
  logic          start_q, start_d;
  logic          rw_q, rw_d;
  logic [4:0]    phy_q, phy_d;
  logic [4:0]    reg_q, reg_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          ack_q, ack_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          link_q, link_d;
  logic          pv_q, pv_d;
  logic [PW-1:0] ptmr_q, ptmr_d;
  logic          pend_q, pend_d;
  logic          wrap, fall, poll_go;

  assign wrap = (div_q == DIV_MAX);
  // Frame-engine inputs only move on MDC falling edges, half a period before it samples.
  assign fall = wrap & mdc_q;

  always_comb begin
    div_d   = wrap ? '0 : div_q + 1'b1;
    mdc_d   = wrap ? ~mdc_q : mdc_q;
    state_d = state_q;
    owner_d = owner_q;
    start_d = start_q;
    rw_d    = rw_q;
    phy_d   = phy_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    link_d  = link_q;
    pv_d    = 1'b0;
    ptmr_d  = ptmr_q;
    pend_d  = pend_q;
    poll_go = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (cmd_req) begin
            rw_d    = cmd_rw;
            phy_d   = cmd_phy;
            reg_d   = cmd_reg;
            wdata_d = cmd_wdata;
            start_d = 1'b1;
            owner_d = 1'b0;
            state_d = RUN;
          end else if (pend_q && poll_en) begin
            rw_d    = 1'b0;
            phy_d   = cmd_phy;
            reg_d   = POLL_REG;
            start_d = 1'b1;
            owner_d = 1'b1;
            poll_go = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (m_done) begin
            if (owner_q)    link_d  = m_rdata[LINK_BIT];
            else if (!rw_q) rdata_d = m_rdata;
            start_d = 1'b0;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          // One MDC rise has seen start low, so the engine is re-armed.
          ack_d   = ~owner_q;
          pv_d    = owner_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      ptmr_d = (ptmr_q == POLL_MAX) ? '0 : ptmr_q + 1'b1;
    end
    if (poll_go) pend_d = 1'b0;
    if (fall && ptmr_q == POLL_MAX) pend_d = 1'b1;
    if (!poll_en) begin
      ptmr_d = '0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      mdc_q   <= 1'b0;
      owner_q <= 1'b0;
      start_q <= 1'b0;
      rw_q    <= 1'b0;
      phy_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      link_q  <= 1'b0;
      pv_q    <= 1'b0;
      ptmr_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      mdc_q   <= mdc_d;
      owner_q <= owner_d;
      start_q <= start_d;
      rw_q    <= rw_d;
      phy_q   <= phy_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      link_q  <= link_d;
      pv_q    <= pv_d;
      ptmr_q  <= ptmr_d;
      pend_q  <= pend_d;
    end
  end

  assign mdc        = mdc_q;
  assign cmd_ack    = ack_q;
  assign cmd_rdata  = rdata_q;
  assign busy       = (state_q != IDLE);
  assign link_up    = link_q;
  assign poll_valid = pv_q;
  assign m_start    = start_q;
  assign m_rw       = rw_q;
  assign m_phy      = phy_q;
  assign m_reg      = reg_q;
  assign m_wdata    = wdata_q;
endmodule

// File: doc/mdio_ctrl.md
# mdio_ctrl

MDIO management sequencer for the RTL8211EG Ethernet controller. It generates the MDC clock from the system clock and accepts single register read/write commands from the host register interface. It runs each command as one frame through the downstream MDIO frame engine (start/rw/done protocol), and in idle time it polls the PHY status register to keep a latched link indication.

## Interface
Parameters:
- MDC_DIV, 25 — clk cycles per MDC half-period; must be ≥ 1. The default gives a 1 µs MDC period at 50 MHz, above the 400 ns minimum.
- POLL_PERIOD, 50000 — MDC periods between automatic status polls; must be ≥ 1.
- POLL_REG, 5'd1 — PHY register read by the automatic poll.
- LINK_BIT, 2 — bit of POLL_REG that is copied to link_up.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- mdc  out  1  MDC clock, to the PHY and to the frame engine.
- cmd_req  in  1  command request, level; held until cmd_ack.
- cmd_rw  in  1  0 = read, 1 = write.
- cmd_phy  in  5  PHY address.
- cmd_reg  in  5  register address.
- cmd_wdata  in  16  write data.
- cmd_ack  out  1  one-clk pulse on completion of a host command.
- cmd_rdata  out  16  read result, valid from cmd_ack until the next host read completes.
- busy  out  1  high while a frame (host or poll) is in progress.
- poll_en  in  1  enables automatic polling.
- link_up  out  1  latched value of POLL_REG[LINK_BIT].
- poll_valid  out  1  one-clk pulse when link_up is updated.
- m_start  out  1  to frame engine: start.
- m_rw  out  1  to frame engine: rw.
- m_phy  out  5  to frame engine: PHY address.
- m_reg  out  5  to frame engine: register address.
- m_wdata  out  16  to frame engine: write data.
- m_rdata  in  16  from frame engine: read data.
- m_done  in  1  from frame engine: frame done.

## Operation
- **MDC generation:** a divider counts 0..MDC_DIV-1; mdc toggles on wrap.
  - fall strobe = wrap while mdc = 1.
  - All FSM state and all m_* outputs change only on the clk edge of a fall strobe. The frame engine samples on MDC rising edges, so its inputs are stable half a period before each rise.
- **FSM states:**
  - IDLE
    - On a fall strobe with cmd_req = 1: latch cmd_rw/phy/reg/wdata into m_*, set m_start = 1, mark the owner as host, go to RUN.
    - Otherwise, on a fall strobe with poll_pend = 1 and poll_en = 1: set m_rw = 0, m_phy = cmd_phy, m_reg = POLL_REG, m_start = 1, mark the owner as poll, go to RUN.
    - The host command has priority when both are pending.
  - RUN — on a fall strobe with m_done = 1:
    - capture m_rdata into cmd_rdata (host read) or m_rdata[LINK_BIT] into link_up (poll);
    - set m_start = 0; go to RELEASE.
  - RELEASE — the next fall strobe; one MDC rise has now passed with start low, which re-arms the frame engine.
    - Pulse cmd_ack (host) or poll_valid (poll) for one clk; go to IDLE.
- busy = 1 in RUN and RELEASE.
- **Poll timer:** counts fall strobes from 0 to POLL_PERIOD-1.
  - On wrap it sets poll_pend; a poll start clears it.
  - poll_en = 0 clears both the timer and poll_pend. An in-flight poll still completes and updates link_up.
- Host writes leave cmd_rdata unchanged. Polls never touch cmd_rdata or cmd_ack.
- cmd_req must drop on cmd_ack. A request still high at the next fall strobe in IDLE is accepted as a new command.

## Timing
- **Reset values:** mdc = 0, divider = 0, FSM = IDLE, m_start = 0, m_rw = 0, m_phy = 0, m_reg = 0, m_wdata = 0, cmd_ack = 0, cmd_rdata = 0, busy = 0, link_up = 0, poll_valid = 0, poll timer = 0, poll_pend = 0.
- **Reset mid-frame:** the frame is abandoned and no ack is issued. The frame engine is reset from the same rst.
- **Frame length:** the frame engine asserts m_done on the 33rd MDC rise after m_start rises. The FSM sees m_done at the following fall, F33, counting from the accepting fall F0.
- **Ack timing:** cmd_ack falls on fall F34.
- **Latency:** from cmd_req rising to cmd_ack is at most 34·2·MDC_DIV + 2·MDC_DIV clk cycles.
- **Back-to-back:** the earliest next acceptance is F35, giving at least one idle MDC period between frames.
- **Poll during a host frame:** poll_pend stays set and the poll runs at the first IDLE fall strobe with no cmd_req.

## Test plan
- **Reset:** MDC_DIV = 2, rst for 5 clk → every output at its reset value; mdc toggles every 2 clk after rst drops.
- **Host write:** phy = 5'h01, reg = 5'h00, wdata = 16'h1140 → m_start high for exactly 33 MDC rises; the frame-engine model receives 0x1140; cmd_ack is one clk wide at F34; cmd_rdata unchanged.
- **Host read:** the model returns 16'h796D → cmd_rdata = 16'h796D at cmd_ack; busy low in the clk after the ack.
- **Poll:** poll_en = 1, POLL_PERIOD = 4, model returns BMSR = 16'h0004 → poll_valid pulse, link_up = 1. Then return 16'h0000 → link_up = 0. cmd_ack never pulses.
- **Collision:** cmd_req and poll_pend both ready at the same fall → host frame first, poll frame next, with start low for at least one MDC rise between them.
- **Mid-frame reset:** rst asserted during RUN → m_start = 0, busy = 0, no cmd_ack; a fresh command then completes normally.
